// File: rtl/hazard_pkg.sv
// Shared types and defaults for the ID-stage hazard detection unit.
//   hz_state_t    : control FSM state encoding
//   RegAwDefault  : default register-address width
//   CntWDefault   : default width of the stall-cycle counter
package hazard_pkg;

  localparam int unsigned RegAwDefault = 3;
  localparam int unsigned CntWDefault  = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD_WAIT = 2'd1,
    HOLD      = 2'd2
  } hz_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk, reset_n : clock, asynchronous active-low reset
//   inc          : count up by one (held at all-ones once reached)
//   clear        : synchronous clear, wins over inc
//   count        : current value
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inc,
  input  logic             clear,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_detection_unit.sv
// ID-stage hazard detection: load-use bubbles, taken-branch flush and
// whole-pipeline freeze while data memory is busy.
//   clk, reset_n          : clock, asynchronous active-low reset
//   id_rs/id_rt, id_use_* : source registers of the ID instruction and their use flags
//   ex_memRead, ex_rd     : EX instruction is a load, and its destination
//   branch_taken          : branch resolved taken in EX this cycle
//   dmem_busy             : data memory not ready
//   stall                 : zero ID/EX controls (bubble)
//   pc_write, ifid_write  : PC / IF/ID load enables
//   ifid_flush            : clear IF/ID (wrong-path kill)
//   pipe_hold             : freeze ID/EX, EX/MEM, MEM/WB
//   stall_cnt             : saturating count of bubble cycles
module hazard_detection_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW     = RegAwDefault,
  parameter int unsigned LOAD_EXTRA = 0,
  parameter int unsigned CNT_W      = CntWDefault
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_memRead,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              branch_taken,
  input  logic              dmem_busy,
  output logic              stall,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic              pipe_hold,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned ExW = (LOAD_EXTRA < 2) ? 1 : $clog2(LOAD_EXTRA + 1);
  localparam logic [ExW-1:0] ExLoad = ExW'(LOAD_EXTRA);

  hz_state_t      state_q, state_d;
  hz_state_t      ret_q, ret_d;
  hz_state_t      eff_state;
  logic [ExW-1:0] extra_q, extra_d;
  logic           lu;
  logic           cnt_inc;

  assign lu = ex_memRead & ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  // Once dmem_busy drops while in HOLD, this cycle already behaves as the saved
  // state so a frozen LOAD_WAIT resumes without an unprotected gap cycle.
  assign eff_state = (state_q == HOLD) ? ret_q : state_q;

  always_comb begin
    state_d    = eff_state;
    ret_d      = ret_q;
    extra_d    = extra_q;
    stall      = 1'b0;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    pipe_hold  = 1'b0;
    cnt_inc    = 1'b0;

    if (!reset_n) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
    end else if (dmem_busy) begin
      pipe_hold  = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      state_d    = HOLD;
      ret_d      = eff_state;
    end else if (branch_taken) begin
      // Redirect wins over any pending load-use bubble.
      stall      = 1'b1;
      ifid_flush = 1'b1;
      cnt_inc    = 1'b1;
      state_d    = IDLE;
      extra_d    = '0;
    end else if (eff_state == LOAD_WAIT) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      cnt_inc    = 1'b1;
      extra_d    = extra_q - ExW'(1);
      if (extra_q <= ExW'(1)) begin
        state_d = IDLE;
        extra_d = '0;
      end
    end else if (lu) begin
      stall      = 1'b1;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      cnt_inc    = 1'b1;
      if (LOAD_EXTRA > 0) begin
        extra_d = ExLoad;
        state_d = LOAD_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ret_q   <= IDLE;
      extra_q <= '0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      extra_q <= extra_d;
    end
  end

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .inc    (cnt_inc),
    .clear  (1'b0),
    .count  (stall_cnt)
  );

endmodule

// File: tb/tb_hazard_detection_unit.sv
module tb_hazard_detection_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [2:0] id_rs, id_rt, ex_rd;
  logic       id_use_rs, id_use_rt, ex_memRead, branch_taken, dmem_busy;

  logic       s0, pw0, iw0, fl0, ph0;
  logic [3:0] cnt0;
  logic       s2, pw2, iw2, fl2, ph2;
  logic [15:0] cnt2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // LOAD_EXTRA=0 with a narrow counter so saturation is cheap to reach.
  hazard_detection_unit #(.REG_AW(3), .LOAD_EXTRA(0), .CNT_W(4)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .stall(s0), .pc_write(pw0), .ifid_write(iw0), .ifid_flush(fl0),
    .pipe_hold(ph0), .stall_cnt(cnt0)
  );

  hazard_detection_unit #(.REG_AW(3), .LOAD_EXTRA(2), .CNT_W(16)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .ex_memRead(ex_memRead),
    .ex_rd(ex_rd), .branch_taken(branch_taken), .dmem_busy(dmem_busy),
    .stall(s2), .pc_write(pw2), .ifid_write(iw2), .ifid_flush(fl2),
    .pipe_hold(ph2), .stall_cnt(cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    id_rs = 3'd0; id_rt = 3'd0; ex_rd = 3'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memRead = 1'b0;
    branch_taken = 1'b0; dmem_busy = 1'b0;
  endtask

  task automatic lu_rs(input logic [2:0] r);
    idle_inputs();
    ex_memRead = 1'b1; ex_rd = r; id_rs = r; id_use_rs = 1'b1;
  endtask

  task automatic lu_rt(input logic [2:0] r);
    idle_inputs();
    ex_memRead = 1'b1; ex_rd = r; id_rt = r; id_use_rt = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 1'b0;
    #1;
    check("rst_stall", 32'(s2), 1);
    check("rst_pc_write", 32'(pw2), 0);
    check("rst_pipe_hold", 32'(ph2), 0);
    check("rst_cnt", 32'(cnt2), 0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    reset_n = 1'b0;
    do_reset();

    // Load-use on rs, no extra cycles: one bubble.
    lu_rs(3'd3); #1;
    check("lu_rs_stall", 32'(s0), 1);
    check("lu_rs_pc_write", 32'(pw0), 0);
    check("lu_rs_ifid_write", 32'(iw0), 0);
    next_cycle(); idle_inputs(); #1;
    check("lu_rs_release_stall", 32'(s0), 0);
    check("lu_rs_release_pc", 32'(pw0), 1);
    check("lu_rs_release_ifid", 32'(iw0), 1);
    check("lu_rs_cnt", 32'(cnt0), 1);

    // No false hazards.
    do_reset();
    idle_inputs(); ex_memRead = 1'b1; ex_rd = 3'd3; id_rt = 3'd3; id_use_rt = 1'b0; #1;
    check("nofalse_unused_rt", 32'(s0), 0);
    next_cycle(); ex_memRead = 1'b0; id_use_rt = 1'b1; #1;
    check("nofalse_not_load", 32'(s0), 0);
    check("nofalse_not_load_x2", 32'(s2), 0);
    next_cycle(); idle_inputs(); #1;
    check("nofalse_cnt", 32'(cnt0), 0);

    // LOAD_EXTRA=2 on rt: three consecutive bubbles.
    do_reset();
    lu_rt(3'd5); #1;
    check("le2_stall_c1", 32'(s2), 1);
    next_cycle(); idle_inputs(); #1;
    check("le2_stall_c2", 32'(s2), 1);
    check("le2_pc_c2", 32'(pw2), 0);
    next_cycle(); #1;
    check("le2_stall_c3", 32'(s2), 1);
    next_cycle(); #1;
    check("le2_release_stall", 32'(s2), 0);
    check("le2_release_pc", 32'(pw2), 1);
    check("le2_cnt", 32'(cnt2), 3);

    // Branch overrides a simultaneous load-use.
    do_reset();
    lu_rs(3'd6); branch_taken = 1'b1; #1;
    check("br_flush", 32'(fl2), 1);
    check("br_stall", 32'(s2), 1);
    check("br_pc_write", 32'(pw2), 1);
    check("br_ifid_write", 32'(iw2), 1);
    check("br_flush_le0", 32'(fl0), 1);
    next_cycle(); idle_inputs(); #1;
    check("br_after_stall", 32'(s2), 0);
    check("br_after_flush", 32'(fl2), 0);
    check("br_cnt", 32'(cnt2), 1);

    // dmem_busy for 4 cycles with one LOAD_WAIT cycle left.
    do_reset();
    lu_rs(3'd2); #1;
    next_cycle(); idle_inputs(); #1;
    check("busy_pre_stall", 32'(s2), 1);
    for (int i = 0; i < 4; i++) begin
      next_cycle(); dmem_busy = 1'b1; #1;
      check("busy_pipe_hold", 32'(ph2), 1);
      check("busy_stall", 32'(s2), 0);
      check("busy_pc_write", 32'(pw2), 0);
      check("busy_flush", 32'(fl2), 0);
      check("busy_cnt_frozen", 32'(cnt2), 2);
    end
    next_cycle(); dmem_busy = 1'b0; #1;
    check("busy_resume_stall", 32'(s2), 1);
    check("busy_resume_hold", 32'(ph2), 0);
    check("busy_resume_pc", 32'(pw2), 0);
    next_cycle(); #1;
    check("busy_done_stall", 32'(s2), 0);
    check("busy_cnt_total", 32'(cnt2), 3);

    // Asynchronous reset in the middle of LOAD_WAIT.
    do_reset();
    lu_rs(3'd1); #1;
    next_cycle(); idle_inputs(); #2;
    reset_n = 1'b0; #1;
    check("arst_stall", 32'(s2), 1);
    check("arst_pc_write", 32'(pw2), 0);
    check("arst_ifid_write", 32'(iw2), 0);
    check("arst_flush", 32'(fl2), 0);
    check("arst_hold", 32'(ph2), 0);
    check("arst_cnt", 32'(cnt2), 0);
    next_cycle(); reset_n = 1'b1; #1;
    check("arst_rel_stall", 32'(s2), 0);
    check("arst_rel_pc", 32'(pw2), 1);
    next_cycle(); #1;
    check("arst_no_residual", 32'(s2), 0);
    check("arst_cnt_after", 32'(cnt2), 0);

    // Saturation: 2^4+5 bubbles on the 4-bit counter.
    do_reset();
    lu_rs(3'd7);
    for (int i = 0; i < 21; i++) begin
      next_cycle();
      if (i == 15) check("sat_reach", 32'(cnt0), 15);
    end
    idle_inputs(); #1;
    check("sat_hold", 32'(cnt0), 15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
